sr_cmd_debouncer: RTL and testbench
===================================

// Module: sr_cmd_debouncer
// PURPOSE
//  Front-end stage feeding the SR flip-flop's s/r inputs. Takes two raw async push-button lines
//  (set, clear), synchronises and debounces each, and emits clean single-cycle s_o/r_o command
//  pulses. s_o and r_o are never asserted together, so the SR stage never sees its 2'b11 (z)
//  code. Simultaneous set+clear requests are dropped and flagged on conflict_o.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive cycles a synced input must differ from its stable level to flip (>=1)
//  SYNC_STAGES      2   flop depth of input synchroniser per channel (>=2)
// PORTS
//  clk         in   1  clock, all state on rising edge
//  rst         in   1  reset, synchronous, active-high
//  set_btn     in   1  raw asynchronous set request (active-high)
//  clr_btn     in   1  raw asynchronous clear request (active-high)
//  s_o         out  1  one-cycle set pulse -> SR flip-flop s
//  r_o         out  1  one-cycle clear pulse -> SR flip-flop r
//  s_lvl       out  1  debounced stable level of set_btn
//  r_lvl       out  1  debounced stable level of clr_btn
//  conflict_o  out  1  one-cycle flag: set and clear rising edges coincided, both dropped
// BEHAVIOUR
//  - Reset: all sync flops, stable levels, edge-history flops, counters and all outputs -> 0.
//    rst dominates every other event on the same edge.
//  - Synchroniser: SYNC_STAGES-deep shift chain per channel; last stage = synced.
//  - Debounce (per channel): cnt width $clog2(DEBOUNCE_CYCLES+1).
//    synced == stable -> cnt <= 0.
//    synced != stable, cnt == DEBOUNCE_CYCLES-1 -> stable <= synced, cnt <= 0.
//    synced != stable otherwise -> cnt <= cnt+1. Any single-cycle return to stable restarts count.
//  - Edge detect: stable_d <= stable each cycle; rise = stable & ~stable_d. Falling edges make no pulse.
//  - Output register (registered each cycle):
//    s_o <= rise_s & ~rise_r;  r_o <= rise_r & ~rise_s;  conflict_o <= rise_s & rise_r.
//    Invariant: s_o & r_o == 0 on every cycle, including during/after reset.
//  - Latency: counting the first rising edge that samples the new raw level as edge 1, s_lvl/r_lvl
//    rise after edge SYNC_STAGES+DEBOUNCE_CYCLES; s_o/r_o high for exactly the cycle after edge
//    SYNC_STAGES+DEBOUNCE_CYCLES+1. Pulse width is always exactly 1 cycle regardless of hold time.
//  - Held button: one pulse per press; no repeat while held. Release then re-press -> new pulse
//    only after full debounce of the release and the new press.
//  - Button held high through reset release: treated as a new press; pulse after normal latency.
//  - Reset mid-count: count discarded; no pulse from the interrupted transition.
//  - Counter never wraps: saturates at flip point and clears.
// STRUCTURE
//  - Sub-module sync_debounce (one channel: synchroniser + counter + stable + stable_d, outputs
//    stable and rise); instantiated twice. Top holds only arbitration/output registers.
//  - Shared package sr_pkg: default DEBOUNCE_CYCLES/SYNC_STAGES constants, shared with the SR
//    flip-flop bench. No typedefs required.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  - Clean press: set_btn 0->1 held 20 cycles -> s_lvl=1 after edge 6, s_o=1 only after edge 7, r_o=0 throughout.
//  - Glitch: set_btn high 3 cycles then low -> s_lvl, s_o stay 0; then 4+ cycle press -> one pulse.
//  - Simultaneous: set_btn and clr_btn rise same cycle -> conflict_o=1 one cycle after edge 7, s_o=r_o=0.
//  - Staggered: clr_btn rises 1 cycle after set_btn -> s_o pulse, then r_o pulse next cycle, never overlapping.
//  - Reset mid-count: press, assert rst at edge 4 for 1 cycle, release button -> no pulse, all outputs 0.
//  - Held through reset: set_btn=1 during rst, rst drops -> exactly one s_o pulse at normal latency.

Source files
------------

// File: rtl/sr_pkg.sv
// sr_pkg: constants shared between the SR command front end and the
// SR flip-flop bench.
//   DEBOUNCE_CYCLES_DEFAULT : cycles a synced input must hold a new level to flip
//   SYNC_STAGES_DEFAULT     : flop depth of each input synchroniser
package sr_pkg;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
endpackage

// File: rtl/sr_cmd_debouncer_sync_debounce.sv
// sync_debounce: one push-button channel. Synchronises a raw asynchronous
// line, debounces it into a stable level and flags the stable level's
// rising edge.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   raw    in  raw asynchronous button line
//   stable out debounced level
//   rise   out high for the cycle after stable goes 0->1
module sync_debounce
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable_d;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      stable_d <= stable;
      // Any cycle back at the stable level restarts the count; the counter
      // clears on the flip, so it never wraps.
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: front end for an SR flip-flop. Debounces raw set/clear
// buttons and issues single-cycle s_o/r_o pulses that are never high
// together; coinciding set and clear presses are dropped and reported.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   set_btn    in  raw asynchronous set request
//   clr_btn    in  raw asynchronous clear request
//   s_o        out one-cycle set pulse
//   r_o        out one-cycle clear pulse
//   s_lvl      out debounced level of set_btn
//   r_lvl      out debounced level of clr_btn
//   conflict_o out one-cycle flag for coinciding set/clear presses
module sr_cmd_debouncer
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s_o,
  output logic r_o,
  output logic s_lvl,
  output logic r_lvl,
  output logic conflict_o
);

  logic rise_s;
  logic rise_r;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_set (
    .clk   (clk),
    .rst   (rst),
    .raw   (set_btn),
    .stable(s_lvl),
    .rise  (rise_s)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_clr (
    .clk   (clk),
    .rst   (rst),
    .raw   (clr_btn),
    .stable(r_lvl),
    .rise  (rise_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_o        <= 1'b0;
      r_o        <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      s_o        <= rise_s & ~rise_r;
      r_o        <= rise_r & ~rise_s;
      conflict_o <= rise_s & rise_r;
    end
  end

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic rst, set_btn, clr_btn;
  logic s_o, r_o, s_lvl, r_lvl, conflict_o;

  always #5 clk = ~clk;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_btn   (set_btn),
    .clr_btn   (clr_btn),
    .s_o       (s_o),
    .r_o       (r_o),
    .s_lvl     (s_lvl),
    .r_lvl     (r_lvl),
    .conflict_o(conflict_o)
  );

  typedef struct {
    logic s, r, sl, rl, c;
  } exp_t;

  // Button windows are in drive cycles k (k is sampled by edge k+1);
  // expectations are in edge numbers, 0 meaning "never".
  typedef struct {
    string name;
    int    s_on, s_off, c_on, c_off;
    int    sl_rise, sl_fall, rl_rise, rl_fall;
    int    s_pulse, r_pulse, c_pulse;
    int    len;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n;

  task automatic chk(input string tag, input string field, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s edge=%0d got=%b exp=%b", tag, field, edge_n, got, exp);
    end
  endtask

  task automatic cyc(input logic r_i, input logic s_i, input logic c_i,
                     input exp_t e, input string tag);
    exp_t x;
    rst = r_i;
    set_btn = s_i;
    clr_btn = c_i;
    sb.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    x = sb.pop_front();
    chk(tag, "s_o", s_o, x.s);
    chk(tag, "r_o", r_o, x.r);
    chk(tag, "s_lvl", s_lvl, x.sl);
    chk(tag, "r_lvl", r_lvl, x.rl);
    chk(tag, "conflict_o", conflict_o, x.c);
    chk(tag, "s_and_r", s_o & r_o, 1'b0);
  endtask

  function automatic vec_t mk(string n, int s_on, int s_off, int c_on, int c_off,
                              int sl_r, int sl_f, int rl_r, int rl_f,
                              int sp, int rp, int cp);
    vec_t v;
    v.name = n; v.s_on = s_on; v.s_off = s_off; v.c_on = c_on; v.c_off = c_off;
    v.sl_rise = sl_r; v.sl_fall = sl_f; v.rl_rise = rl_r; v.rl_fall = rl_f;
    v.s_pulse = sp; v.r_pulse = rp; v.c_pulse = cp; v.len = 30;
    return v;
  endfunction

  exp_t zero;
  vec_t vecs[6];

  initial begin
    zero = '{s: 1'b0, r: 1'b0, sl: 1'b0, rl: 1'b0, c: 1'b0};
    vecs[0] = mk("clean_set",   0, 20, 0, 0,   6, 26, 0, 0,   7, 0, 0);
    vecs[1] = mk("clean_clr",   0, 0,  2, 12,  0, 0,  8, 18,  0, 9, 0);
    vecs[2] = mk("glitch",      0, 3,  0, 0,   0, 0,  0, 0,   0, 0, 0);
    vecs[3] = mk("short_press", 0, 4,  0, 0,   6, 10, 0, 0,   7, 0, 0);
    vecs[4] = mk("simultan",    0, 20, 0, 20,  6, 26, 6, 26,  0, 0, 7);
    vecs[5] = mk("stagger",     0, 20, 1, 21,  6, 26, 7, 27,  7, 8, 0);

    // Reset state, with set held high through reset.
    edge_n = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, zero, "reset");

    // Held through reset release: a fresh press at normal latency.
    edge_n = 0;
    for (int e = 1; e <= 30; e++) begin
      exp_t x = zero;
      x.sl = (e >= 6 && e < 26);
      x.s  = (e == 7);
      cyc(1'b0, (e <= 20), 1'b0, x, "held_thru_rst");
    end

    // Table-driven scenarios, run back to back from a quiet state.
    foreach (vecs[i]) begin
      vec_t v = vecs[i];
      edge_n = 0;
      for (int k = 0; k < v.len; k++) begin
        exp_t x;
        int e = k + 1;
        x.sl = (e >= v.sl_rise && e < v.sl_fall);
        x.rl = (e >= v.rl_rise && e < v.rl_fall);
        x.s  = (e == v.s_pulse);
        x.r  = (e == v.r_pulse);
        x.c  = (e == v.c_pulse);
        cyc(1'b0, (k >= v.s_on && k < v.s_off), (k >= v.c_on && k < v.c_off), x, v.name);
      end
    end

    // Reset mid-count: the interrupted press produces nothing.
    edge_n = 0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, zero, "rst_mid");
    cyc(1'b1, 1'b1, 1'b0, zero, "rst_mid");
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0, zero, "rst_mid");

    // Release then re-press: a second, separate pulse after full debounce.
    edge_n = 0;
    for (int e = 1; e <= 40; e++) begin
      exp_t x = zero;
      x.sl = (e >= 6 && e < 16) || (e >= 26 && e < 36);
      x.s  = (e == 7) || (e == 27);
      cyc(1'b0, (e <= 10) || (e > 20 && e <= 30), 1'b0, x, "repress");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
